// File: rtl/lsb_multi_cdb.sv
// In-order load/store buffer with multi-channel CDB wakeup.
// Loads run once rs1 is ready; stores wait for ROB commit.
module lsb_multi_cdb #(
  parameter int LSB_DEPTH = 16,
  parameter int ROB_POS_W = 5,
  parameter int NUM_CDB   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  input  logic                           rollback,
  input  logic                           issue_enable,
  input  logic                           issue_is_store,
  input  logic [2:0]                     issue_funct3,
  input  logic [ROB_POS_W-1:0]           issue_rob_pos,
  input  logic [31:0]                    issue_rs1_val,
  input  logic                           issue_rs1_pend,
  input  logic [ROB_POS_W-1:0]           issue_rs1_tag,
  input  logic [31:0]                    issue_rs2_val,
  input  logic                           issue_rs2_pend,
  input  logic [ROB_POS_W-1:0]           issue_rs2_tag,
  input  logic [31:0]                    issue_imm,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_POS_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*32-1:0]          cdb_val,
  input  logic                           rob_store_commit,
  input  logic [ROB_POS_W-1:0]           rob_store_tag,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [2:0]                     mem_ls_type,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_store_val,
  input  logic                           mem_finish,
  input  logic [31:0]                    mem_load_val,
  output logic                           next_full,
  output logic                           result_valid,
  output logic [ROB_POS_W-1:0]           result_tag,
  output logic [31:0]                    result_val
);
  localparam int PW = $clog2(LSB_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                 valid;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [ROB_POS_W-1:0] rob_pos;
    logic [31:0]          rs1_val;
    logic                 rs1_pend;
    logic [ROB_POS_W-1:0] rs1_tag;
    logic [31:0]          rs2_val;
    logic                 rs2_pend;
    logic [ROB_POS_W-1:0] rs2_tag;
    logic [31:0]          imm;
    logic                 committed;
  } ent_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  ent_t                 ent_q [LSB_DEPTH];
  ent_t                 ent_d [LSB_DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d, cc_q, cc_d;
  state_t               state_q, state_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [2:0]           mem_ls_type_q, mem_ls_type_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_store_val_q, mem_store_val_d;
  logic                 result_valid_q, result_valid_d;
  logic [ROB_POS_W-1:0] result_tag_q, result_tag_d;
  logic [31:0]          result_val_q, result_val_d;
  ent_t                 hd, nx, sel;
  logic                 pop, pop_st, push, cmt, start;

  // Lowest channel wins: scan high to low so the last hit sticks.
  function automatic logic [32:0] wake(
    input logic                 pend,
    input logic [ROB_POS_W-1:0] tag,
    input logic [31:0]          val
  );
    logic [32:0] r;
    r = {pend, val};
    if (pend) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] &&
            cdb_tag[k*ROB_POS_W +: ROB_POS_W] == tag)
          r = {1'b0, cdb_val[k*32 +: 32]};
      end
    end
    return r;
  endfunction

  function automatic logic exec_ok(input ent_t e);
    return e.valid && !e.rs1_pend &&
      (!e.is_store || (e.committed && !e.rs2_pend));
  endfunction

  function automatic logic [31:0] ext(
    input logic [2:0]  f3,
    input logic [31:0] raw
  );
    logic [31:0] r;
    r = raw;
    unique case (1'b1)
      f3 == 3'b000: r = {{24{raw[7]}}, raw[7:0]};
      f3 == 3'b001: r = {{16{raw[15]}}, raw[15:0]};
      f3 == 3'b100: r = {24'b0, raw[7:0]};
      f3 == 3'b101: r = {16'b0, raw[15:0]};
      default:      r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    ent_d           = ent_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    cc_d            = cc_q;
    state_d         = state_q;
    mem_enable_d    = mem_enable_q;
    mem_wr_d        = mem_wr_q;
    mem_ls_type_d   = mem_ls_type_q;
    mem_addr_d      = mem_addr_q;
    mem_store_val_d = mem_store_val_q;
    result_valid_d  = result_valid_q;
    result_tag_d    = result_tag_q;
    result_val_d    = result_val_q;
    pop             = 1'b0;
    pop_st          = 1'b0;
    push            = 1'b0;
    cmt             = 1'b0;
    start           = 1'b0;
    hd              = ent_q[head_q];
    nx              = ent_q[head_q + PW'(1)];
    sel             = (state_q == REQ) ? nx : hd;
    if (rdy) begin
      result_valid_d = 1'b0;
      for (int i = 0; i < LSB_DEPTH; i++) begin
        {ent_d[i].rs1_pend, ent_d[i].rs1_val} =
          wake(ent_q[i].rs1_pend, ent_q[i].rs1_tag, ent_q[i].rs1_val);
        {ent_d[i].rs2_pend, ent_d[i].rs2_val} =
          wake(ent_q[i].rs2_pend, ent_q[i].rs2_tag, ent_q[i].rs2_val);
      end
      unique case (state_q)
        IDLE: begin
          if (!rollback && exec_ok(hd))
            start = 1'b1;
        end
        REQ: begin
          if (mem_finish) begin
            pop    = 1'b1;
            pop_st = hd.is_store;
            if (!hd.is_store && !rollback) begin
              result_valid_d = 1'b1;
              result_tag_d   = hd.rob_pos;
              result_val_d   = ext(mem_ls_type_q, mem_load_val);
            end
            if (!rollback && exec_ok(nx)) begin
              start = 1'b1;
            end else begin
              state_d      = IDLE;
              mem_enable_d = 1'b0;
            end
          end else if (rollback && !hd.is_store) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mem_finish) begin
            state_d      = IDLE;
            mem_enable_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        state_d         = REQ;
        mem_enable_d    = 1'b1;
        mem_wr_d        = sel.is_store;
        mem_ls_type_d   = sel.funct3;
        mem_addr_d      = sel.rs1_val + sel.imm;
        mem_store_val_d = sel.rs2_val;
      end
      if (pop) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + PW'(1);
      end
      push = issue_enable && !rollback;
      if (push) begin
        ent_d[tail_q].valid     = 1'b1;
        ent_d[tail_q].is_store  = issue_is_store;
        ent_d[tail_q].funct3    = issue_funct3;
        ent_d[tail_q].rob_pos   = issue_rob_pos;
        ent_d[tail_q].rs1_tag   = issue_rs1_tag;
        ent_d[tail_q].rs2_tag   = issue_rs2_tag;
        ent_d[tail_q].imm       = issue_imm;
        ent_d[tail_q].committed = 1'b0;
        {ent_d[tail_q].rs1_pend, ent_d[tail_q].rs1_val} =
          wake(issue_rs1_pend, issue_rs1_tag, issue_rs1_val);
        {ent_d[tail_q].rs2_pend, ent_d[tail_q].rs2_val} =
          wake(issue_rs2_pend, issue_rs2_tag, issue_rs2_val);
        tail_d = tail_q + PW'(1);
      end
      if (rob_store_commit && !rollback) begin
        for (int i = 0; i < LSB_DEPTH; i++) begin
          if (!cmt && ent_q[i].valid && ent_q[i].is_store &&
              !ent_q[i].committed &&
              ent_q[i].rob_pos == rob_store_tag) begin
            ent_d[i].committed = 1'b1;
            cmt = 1'b1;
          end
        end
      end
      if (rollback) begin
        // Committed stores always sit at the front, so tail follows them.
        for (int i = 0; i < LSB_DEPTH; i++)
          if (!ent_d[i].committed) ent_d[i].valid = 1'b0;
        cc_d    = cc_q - CW'(pop_st);
        count_d = cc_d;
        tail_d  = head_d + cc_d[PW-1:0];
      end else begin
        cc_d    = cc_q + CW'(cmt) - CW'(pop_st);
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign next_full     = (count_d == CW'(LSB_DEPTH));
  assign mem_enable    = mem_enable_q;
  assign mem_wr        = mem_wr_q;
  assign mem_ls_type   = mem_ls_type_q;
  assign mem_addr      = mem_addr_q;
  assign mem_store_val = mem_store_val_q;
  assign result_valid  = result_valid_q;
  assign result_tag    = result_tag_q;
  assign result_val    = result_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LSB_DEPTH; i++) ent_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      cc_q            <= '0;
      state_q         <= IDLE;
      mem_enable_q    <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_ls_type_q   <= '0;
      mem_addr_q      <= '0;
      mem_store_val_q <= '0;
      result_valid_q  <= 1'b0;
      result_tag_q    <= '0;
      result_val_q    <= '0;
    end else begin
      ent_q           <= ent_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      cc_q            <= cc_d;
      state_q         <= state_d;
      mem_enable_q    <= mem_enable_d;
      mem_wr_q        <= mem_wr_d;
      mem_ls_type_q   <= mem_ls_type_d;
      mem_addr_q      <= mem_addr_d;
      mem_store_val_q <= mem_store_val_d;
      result_valid_q  <= result_valid_d;
      result_tag_q    <= result_tag_d;
      result_val_q    <= result_val_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && push) |-> (count_q != CW'(LSB_DEPTH) || pop));

endmodule
